mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit_byte_lane.sv | 51 +++++
 rtl/mem_access_unit.sv | 102 ++++++++++
 tb/tb_mem_access_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: transfer sizes, FSM states
// and the default RAM depth.
package mem_pkg;

  localparam int DEPTH_DEFAULT = 1001;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bus of the memory access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Big-endian lane handling: extracts and extends load lanes, merges store
// lanes into the captured RAM word. Purely combinational.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]         byte_sh;
  logic [4:0]         half_sh;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic [31:0]        lane_mask;
  logic [31:0]        lane_data;

  always_comb begin
    // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
    byte_sh   = {~offset, 3'b000};
    half_sh   = {~offset[1], 4'b0000};
    byte_lane = 8'(word >> byte_sh);
    half_lane = 16'(word >> half_sh);
    byte_s    = byte_lane;
    half_s    = half_lane;
    load_data = word;
    lane_mask = '1;
    lane_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = sign_ext ? 32'(byte_s) : 32'(byte_lane);
        lane_mask = 32'h0000_00FF << byte_sh;
        lane_data = {24'd0, wdata[7:0]} << byte_sh;
      end
      SZ_HALF: begin
        load_data = sign_ext ? 32'(half_s) : 32'(half_lane);
        lane_mask = 32'h0000_FFFF << half_sh;
        lane_data = {16'd0, wdata[15:0]} << half_sh;
      end
      default: ;
    endcase
    merged = (word & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns CPU byte/half/word loads and stores into word
// accesses on a single-port RAM, with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  mem_access_unit_if.slave cpu,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writedata,
  output logic        ram_load,
  input  logic [31:0] ram_out
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic        error_q;
  logic        illegal;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    illegal = 1'b0;
    case (cpu.req_size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = cpu.req_addr[0];
      SZ_WORD: illegal = |cpu.req_addr[1:0];
      default: illegal = 1'b1;
    endcase
    if ({2'b00, cpu.req_addr[31:2]} >= DEPTH_W) illegal = 1'b1;
  end

  byte_lane_unit u_lane (
    .word      (data_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req_valid) begin
            addr_q   <= cpu.req_addr;
            wdata_q  <= cpu.req_wdata;
            size_q   <= cpu.req_size;
            signed_q <= cpu.req_signed;
            write_q  <= cpu.req_write;
            data_q   <= '0;
            error_q  <= illegal;
            // Word stores overwrite every lane, so they skip the RAM read.
            if (illegal)
              state <= ST_RESP;
            else if (cpu.req_write && cpu.req_size == SZ_WORD)
              state <= ST_WRITE;
            else
              state <= ST_READ;
          end
        end
        ST_READ: begin
          data_q <= ram_out;
          state  <= write_q ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP: if (cpu.resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu.req_ready  = (state == ST_IDLE);
  assign cpu.resp_valid = (state == ST_RESP);
  assign cpu.resp_error = error_q;
  assign cpu.resp_rdata = (write_q || error_q) ? '0 : load_data;

  assign ram_address    = {2'b00, addr_q[31:2]};
  assign ram_load       = (state == ST_WRITE);
  assign ram_writedata  = ram_load ? merged : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural transaction model.
module tb_mem_access_unit;

  localparam int DEPTH = 1001;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] neww;
    int          edges;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ram_address;
  logic [31:0] ram_writedata;
  logic        ram_load;
  logic [31:0] ram_out;
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] mdl [0:DEPTH-1];
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_access_unit_if cpu();

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu           (cpu),
    .ram_address   (ram_address),
    .ram_writedata (ram_writedata),
    .ram_load      (ram_load),
    .ram_out       (ram_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'h8001_FFFF;
    if (i == 2) return 32'h1122_3344;
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign ram_out = (ram_address < 32'(DEPTH)) ? ram[ram_address[9:0]] : 32'hDEAD_BEEF;

  // Attached RAM: combinational read, write on the clock edge when ram_load.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (ram_load && ram_address < 32'(DEPTH)) ram[ram_address[9:0]] <= ram_writedata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Transaction-level reference: big-endian lanes held as a byte array.
  function automatic exp_t model(logic [31:0] addr, logic [1:0] size, logic sgn,
                                 logic wr, logic [31:0] wdata, logic [31:0] w);
    exp_t        e;
    logic [7:0]  b [4];
    logic [15:0] h;
    int          o;
    o = int'(addr[1:0]);
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
    e.rdata = 32'd0;
    e.neww  = w;
    if (!e.err) begin
      if (!wr) begin
        case (size)
          2'b00: e.rdata = (sgn && b[o][7]) ? (32'hFFFF_FF00 | 32'(b[o])) : 32'(b[o]);
          2'b01: begin
            h = {b[o], b[o+1]};
            e.rdata = (sgn && h[15]) ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
          end
          default: e.rdata = w;
        endcase
      end else begin
        case (size)
          2'b00: b[o] = wdata[7:0];
          2'b01: begin
            b[o]   = wdata[15:8];
            b[o+1] = wdata[7:0];
          end
          default: ;
        endcase
        e.neww = (size == 2'b10) ? wdata : {b[0], b[1], b[2], b[3]};
      end
    end
    e.edges = e.err ? 1 : ((wr && size != 2'b10) ? 3 : 2);
    return e;
  endfunction

  // Compare process: tracks the expected transaction and checks outputs every cycle.
  initial begin : compare
    int   phase;
    int   n;
    int   idx;
    logic mw;
    logic first;
    exp_t e;
    phase = 0;
    n     = 0;
    idx   = 0;
    mw    = 1'b0;
    first = 1'b0;
    e     = '{err: 1'b0, rdata: 32'd0, neww: 32'd0, edges: 1};
    for (int i = 0; i < DEPTH; i++) mdl[i] = init_val(i);
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req_ready", 32'(cpu.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(cpu.resp_valid), 32'd0);
        chk("rst_resp_error", 32'(cpu.resp_error), 32'd0);
        chk("rst_resp_rdata", cpu.resp_rdata, 32'd0);
        chk("rst_ram_load", 32'(ram_load), 32'd0);
        chk("rst_ram_writedata", ram_writedata, 32'd0);
        chk("rst_ram_address", ram_address, 32'd0);
        phase = 0;
      end else begin
        case (phase)
          0: begin
            chk("idle_req_ready", 32'(cpu.req_ready), 32'd1);
            chk("idle_resp_valid", 32'(cpu.resp_valid), 32'd0);
            chk("idle_ram_load", 32'(ram_load), 32'd0);
          end
          1: begin
            chk("busy_req_ready", 32'(cpu.req_ready), 32'd0);
            chk("busy_resp_valid", 32'(cpu.resp_valid), 32'd0);
            chk("busy_ram_load", 32'(ram_load), 32'(mw && n == e.edges - 1));
            if (mw && n == e.edges - 1) begin
              chk("write_address", ram_address, 32'(idx));
              chk("write_data", ram_writedata, e.neww);
            end
          end
          default: begin
            chk("resp_valid", 32'(cpu.resp_valid), 32'd1);
            chk("resp_req_ready", 32'(cpu.req_ready), 32'd0);
            chk("resp_ram_load", 32'(ram_load), 32'd0);
            chk("resp_rdata", cpu.resp_rdata, e.rdata);
            chk("resp_error", 32'(cpu.resp_error), 32'(e.err));
            if (first && mw && idx < DEPTH) chk("ram_word", ram[idx], mdl[idx]);
          end
        endcase
        case (phase)
          0: if (cpu.req_valid) begin
            idx   = int'(cpu.req_addr >> 2);
            mw    = cpu.req_write;
            e     = model(cpu.req_addr, cpu.req_size, cpu.req_signed, cpu.req_write,
                          cpu.req_wdata, (idx < DEPTH) ? mdl[idx] : 32'd0);
            n     = 1;
            first = 1'b1;
            phase = (e.edges == 1) ? 2 : 1;
          end
          1: begin
            if (mw && !e.err && n == e.edges - 1) mdl[idx] = e.neww;
            n++;
            if (n == e.edges) phase = 2;
          end
          default: begin
            first = 1'b0;
            if (cpu.resp_ready) phase = 0;
          end
        endcase
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int edges);
    logic seen;
    seen  = 1'b0;
    edges = 0;
    rdata = 32'd0;
    err   = 1'b0;
    cpu.req_write  = wr;
    cpu.req_size   = size;
    cpu.req_signed = sgn;
    cpu.req_addr   = addr;
    cpu.req_wdata  = wdata;
    cpu.req_valid  = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = cpu.req_ready;
      @(posedge clock);
      #1;
      cpu.resp_ready = 1'b0;
    end
    cpu.req_valid = 1'b0;
    if (!seen) begin
      timeout("accept_wait");
      return;
    end
    cpu.req_addr   = $urandom;
    cpu.req_wdata  = $urandom;
    cpu.req_size   = 2'($urandom);
    cpu.req_write  = 1'($urandom);
    cpu.req_signed = 1'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (cpu.resp_valid) begin
        seen  = 1'b1;
        edges = k + 1;
        rdata = cpu.resp_rdata;
        err   = cpu.resp_error;
      end
    end
    if (!seen) begin
      timeout("resp_wait");
      return;
    end
    repeat (hold) begin
      @(posedge clock);
      #1;
    end
    cpu.resp_ready = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
    cpu.resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] rd;
    logic        er;
    int          ed;
    logic        seen;
    logic [31:0] a;
    logic [1:0]  sz;
    int          sel;
    int          diff;
    cpu.req_valid  = 1'b0;
    cpu.req_write  = 1'b0;
    cpu.req_size   = 2'b00;
    cpu.req_signed = 1'b0;
    cpu.req_addr   = 32'd0;
    cpu.req_wdata  = 32'd0;
    cpu.resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_req_ready", 32'(cpu.req_ready), 32'd1);
    chk("reset_ram_load", 32'(ram_load), 32'd0);
    reset = 1'b0;
    idle_cycle();

    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB, 1, rd, er, ed);
    idle_cycle();
    chk("bstore_edges", 32'(ed), 32'd3);
    chk("bstore_rdata", rd, 32'd0);
    chk("bstore_ram2", ram[2], 32'h11AB_3344);
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1, rd, er, ed);
    idle_cycle();
    chk("bload_rdata", rd, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1, rd, er, ed);
    idle_cycle();
    chk("hload_rdata", rd, 32'h0000_8001);
    chk("hload_edges", 32'(ed), 32'd2);
    do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFE_F00D, 1, rd, er, ed);
    idle_cycle();
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_edges", 32'(ed), 32'd1);
    chk("misalign_ram1", ram[1], init_val(1));
    do_req(1'b0, 2'b10, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1, rd, er, ed);
    idle_cycle();
    chk("last_word_err", 32'(er), 32'd0);
    chk("last_word_rdata", rd, init_val(DEPTH - 1));
    do_req(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 1, rd, er, ed);
    idle_cycle();
    chk("past_end_err", 32'(er), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, rd, er, ed);
    idle_cycle();
    chk("top_addr_err", 32'(er), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5, rd, er, ed);
    chk("backpressure_rdata", cpu.resp_rdata, init_val(5));
    chk("backpressure_ready", 32'(cpu.req_ready), 32'd0);
    idle_cycle();

    // Reset lands in the WRITE cycle of a halfword store to word 7.
    cpu.req_write  = 1'b1;
    cpu.req_size   = 2'b01;
    cpu.req_signed = 1'b0;
    cpu.req_addr   = 32'h1E;
    cpu.req_wdata  = 32'h0000_5555;
    cpu.req_valid  = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    cpu.req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(posedge clock);
      #1;
      seen = ram_load;
    end
    if (!seen) timeout("write_wait");
    reset = 1'b1;
    #1;
    chk("abort_ram_load", 32'(ram_load), 32'd0);
    chk("abort_req_ready", 32'(cpu.req_ready), 32'd1);
    chk("abort_resp_valid", 32'(cpu.resp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_ram7", ram[7], init_val(7));
    idle_cycle();

    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 6)
        a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      else if (sel == 6)
        a = 32'(DEPTH - 1 + int'($urandom_range(0, 1))) * 32'd4 + 32'($urandom_range(0, 3));
      else
        a = $urandom;
      sel = int'($urandom_range(0, 7));
      sz  = (sel < 3) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(1, 4)), rd, er, ed);
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end
    idle_cycle();
    repeat (2) idle_cycle();

    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== mdl[i]) diff++;
    chk("ram_sweep_diffs", 32'(diff), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
